// File: rtl/fp2_res_unpack_pkg.sv
// Shared sizing helpers, FSM encoding and target-pair selectors for the result unpacker.
package fp2_res_unpack_pkg;

    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Digit count rounded up to even so every packed word holds two digits.
    function automatic int unsigned width_of(input int unsigned width_real);
        return ((width_real + 1) / 2) * 2;
    endfunction

    function automatic int unsigned res_depth_of(input int unsigned width_real);
        return width_of(width_real) / 2;
    endfunction

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRead = 3'd1,
        StWrHi = 3'd2,
        StWrLo = 3'd3,
        StFin  = 3'd4
    } state_e;

    localparam logic TargetA = 1'b0;
    localparam logic TargetB = 1'b1;

endpackage

// File: rtl/fp2_res_wr_demux.sv
// Steers one digit write (sub and add halves) to either the a-pair or the b-pair.
module fp2_res_wr_demux
    import fp2_res_unpack_pkg::*;
#(
    parameter int unsigned RADIX   = 32,
    parameter int unsigned WrAddrW = 4
) (
    input  logic               target_i,
    input  logic               wr_en_i,
    input  logic [WrAddrW-1:0] wr_addr_i,
    input  logic [RADIX-1:0]   sub_din_i,
    input  logic [RADIX-1:0]   add_din_i,
    output logic               mem_a_0_wr_en_o,
    output logic [WrAddrW-1:0] mem_a_0_wr_addr_o,
    output logic [RADIX-1:0]   mem_a_0_din_o,
    output logic               mem_a_1_wr_en_o,
    output logic [WrAddrW-1:0] mem_a_1_wr_addr_o,
    output logic [RADIX-1:0]   mem_a_1_din_o,
    output logic               mem_b_0_wr_en_o,
    output logic [WrAddrW-1:0] mem_b_0_wr_addr_o,
    output logic [RADIX-1:0]   mem_b_0_din_o,
    output logic               mem_b_1_wr_en_o,
    output logic [WrAddrW-1:0] mem_b_1_wr_addr_o,
    output logic [RADIX-1:0]   mem_b_1_din_o
);

    always_comb begin
        mem_a_0_wr_en_o   = 1'b0;
        mem_a_0_wr_addr_o = '0;
        mem_a_0_din_o     = '0;
        mem_a_1_wr_en_o   = 1'b0;
        mem_a_1_wr_addr_o = '0;
        mem_a_1_din_o     = '0;
        mem_b_0_wr_en_o   = 1'b0;
        mem_b_0_wr_addr_o = '0;
        mem_b_0_din_o     = '0;
        mem_b_1_wr_en_o   = 1'b0;
        mem_b_1_wr_addr_o = '0;
        mem_b_1_din_o     = '0;
        unique case (target_i)
            TargetA: begin
                mem_a_0_wr_en_o   = wr_en_i;
                mem_a_0_wr_addr_o = wr_addr_i;
                mem_a_0_din_o     = sub_din_i;
                mem_a_1_wr_en_o   = wr_en_i;
                mem_a_1_wr_addr_o = wr_addr_i;
                mem_a_1_din_o     = add_din_i;
            end
            TargetB: begin
                mem_b_0_wr_en_o   = wr_en_i;
                mem_b_0_wr_addr_o = wr_addr_i;
                mem_b_0_din_o     = sub_din_i;
                mem_b_1_wr_en_o   = wr_en_i;
                mem_b_1_wr_addr_o = wr_addr_i;
                mem_b_1_din_o     = add_din_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fp2_res_unpack.sv
// Reads packed two-digit Fp2 results and writes them digit by digit into the
// next multiplication's a- or b-operand memories.
module fp2_res_unpack
    import fp2_res_unpack_pkg::*;
#(
    parameter int unsigned RADIX      = 32,
    parameter int unsigned WIDTH_REAL = 14,
    localparam int unsigned RES_DEPTH = res_depth_of(WIDTH_REAL),
    localparam int unsigned RdAddrW   = clog2_min1(RES_DEPTH),
    localparam int unsigned WrAddrW   = clog2_min1(WIDTH_REAL)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 target_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sub_res_rd_en_o,
    output logic [RdAddrW-1:0]   sub_res_rd_addr_o,
    input  logic [2*RADIX-1:0]   sub_res_dout_i,
    output logic                 add_res_rd_en_o,
    output logic [RdAddrW-1:0]   add_res_rd_addr_o,
    input  logic [2*RADIX-1:0]   add_res_dout_i,
    output logic                 mem_a_0_wr_en_o,
    output logic [WrAddrW-1:0]   mem_a_0_wr_addr_o,
    output logic [RADIX-1:0]     mem_a_0_din_o,
    output logic                 mem_a_1_wr_en_o,
    output logic [WrAddrW-1:0]   mem_a_1_wr_addr_o,
    output logic [RADIX-1:0]     mem_a_1_din_o,
    output logic                 mem_b_0_wr_en_o,
    output logic [WrAddrW-1:0]   mem_b_0_wr_addr_o,
    output logic [RADIX-1:0]     mem_b_0_din_o,
    output logic                 mem_b_1_wr_en_o,
    output logic [WrAddrW-1:0]   mem_b_1_wr_addr_o,
    output logic [RADIX-1:0]     mem_b_1_din_o
);

    localparam bit                 OddWidth = (WIDTH_REAL % 2) == 1;
    localparam logic [RdAddrW-1:0] LastWord = RdAddrW'(RES_DEPTH - 1);

    state_e             state_q, state_d;
    logic [RdAddrW-1:0] i_q, i_d;
    logic               target_q, target_d;
    logic [RADIX-1:0]   hold_sub_q, hold_sub_d;
    logic [RADIX-1:0]   hold_add_q, hold_add_d;

    logic               rd_en;
    logic [RdAddrW-1:0] rd_addr;
    logic               wr_en;
    logic [WrAddrW-1:0] wr_addr;
    logic [RADIX-1:0]   sub_din;
    logic [RADIX-1:0]   add_din;
    logic               last_word;

    assign last_word = (i_q == LastWord);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            i_q        <= '0;
            target_q   <= TargetA;
            hold_sub_q <= '0;
            hold_add_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            target_q   <= target_d;
            hold_sub_q <= hold_sub_d;
            hold_add_q <= hold_add_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        target_d   = target_q;
        hold_sub_d = hold_sub_q;
        hold_add_d = hold_add_q;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        sub_din    = '0;
        add_din    = '0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    target_d = target_i;
                    i_d      = '0;
                    state_d  = StRead;
                end
            end
            StRead: begin
                busy_o  = 1'b1;
                rd_en   = 1'b1;
                rd_addr = i_q;
                state_d = StWrHi;
            end
            StWrHi: begin
                busy_o     = 1'b1;
                wr_en      = 1'b1;
                wr_addr    = WrAddrW'({i_q, 1'b0});
                sub_din    = sub_res_dout_i[2*RADIX-1:RADIX];
                add_din    = add_res_dout_i[2*RADIX-1:RADIX];
                hold_sub_d = sub_res_dout_i[RADIX-1:0];
                hold_add_d = add_res_dout_i[RADIX-1:0];
                // With an odd digit count the last word's low half is padding.
                state_d    = (OddWidth && last_word) ? StFin : StWrLo;
            end
            StWrLo: begin
                busy_o  = 1'b1;
                wr_en   = 1'b1;
                wr_addr = WrAddrW'({i_q, 1'b1});
                sub_din = hold_sub_q;
                add_din = hold_add_q;
                if (!last_word) begin
                    // Prefetch the next word so WR_HI follows without a bubble.
                    rd_en   = 1'b1;
                    rd_addr = i_q + RdAddrW'(1);
                    i_d     = i_q + RdAddrW'(1);
                    state_d = StWrHi;
                end else begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign sub_res_rd_en_o   = rd_en;
    assign add_res_rd_en_o   = rd_en;
    assign sub_res_rd_addr_o = rd_addr;
    assign add_res_rd_addr_o = rd_addr;

    fp2_res_wr_demux #(
        .RADIX   (RADIX),
        .WrAddrW (WrAddrW)
    ) u_wr_demux (
        .target_i          (target_q),
        .wr_en_i           (wr_en),
        .wr_addr_i         (wr_addr),
        .sub_din_i         (sub_din),
        .add_din_i         (add_din),
        .mem_a_0_wr_en_o   (mem_a_0_wr_en_o),
        .mem_a_0_wr_addr_o (mem_a_0_wr_addr_o),
        .mem_a_0_din_o     (mem_a_0_din_o),
        .mem_a_1_wr_en_o   (mem_a_1_wr_en_o),
        .mem_a_1_wr_addr_o (mem_a_1_wr_addr_o),
        .mem_a_1_din_o     (mem_a_1_din_o),
        .mem_b_0_wr_en_o   (mem_b_0_wr_en_o),
        .mem_b_0_wr_addr_o (mem_b_0_wr_addr_o),
        .mem_b_0_din_o     (mem_b_0_din_o),
        .mem_b_1_wr_en_o   (mem_b_1_wr_en_o),
        .mem_b_1_wr_addr_o (mem_b_1_wr_addr_o),
        .mem_b_1_din_o     (mem_b_1_din_o)
    );

endmodule

// File: tb/tb_fp2_res_unpack.sv
// Bench for fp2_res_unpack: an even (32-bit, 14-digit) and an odd (16-bit, 7-digit) instance.
module tb_fp2_res_unpack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni, start, target, use_odd;
    logic e_start, o_start;
    assign e_start = start & ~use_odd;
    assign o_start = start & use_odd;

    int checks = 0;
    int errors = 0;

    logic [63:0] res_sub[8];
    logic [63:0] res_add[8];

    // Even instance
    logic        e_busy, e_done, e_sub_rd_en, e_add_rd_en;
    logic [2:0]  e_sub_rd_addr, e_add_rd_addr;
    logic [63:0] e_sub_dout, e_add_dout;
    logic        e_wen[4];
    logic [3:0]  e_wa[4];
    logic [31:0] e_wd[4];

    // Odd instance
    logic        o_busy, o_done, o_sub_rd_en, o_add_rd_en;
    logic [1:0]  o_sub_rd_addr, o_add_rd_addr;
    logic [31:0] o_sub_dout, o_add_dout;
    logic        o_wen[4];
    logic [2:0]  o_wa[4];
    logic [15:0] o_wd[4];

    fp2_res_unpack #(.RADIX(32), .WIDTH_REAL(14)) dut_e (
        .clk_i (clk), .rst_ni (rst_ni), .start_i (e_start), .target_i (target),
        .busy_o (e_busy), .done_o (e_done),
        .sub_res_rd_en_o (e_sub_rd_en), .sub_res_rd_addr_o (e_sub_rd_addr),
        .sub_res_dout_i (e_sub_dout),
        .add_res_rd_en_o (e_add_rd_en), .add_res_rd_addr_o (e_add_rd_addr),
        .add_res_dout_i (e_add_dout),
        .mem_a_0_wr_en_o (e_wen[0]), .mem_a_0_wr_addr_o (e_wa[0]), .mem_a_0_din_o (e_wd[0]),
        .mem_a_1_wr_en_o (e_wen[1]), .mem_a_1_wr_addr_o (e_wa[1]), .mem_a_1_din_o (e_wd[1]),
        .mem_b_0_wr_en_o (e_wen[2]), .mem_b_0_wr_addr_o (e_wa[2]), .mem_b_0_din_o (e_wd[2]),
        .mem_b_1_wr_en_o (e_wen[3]), .mem_b_1_wr_addr_o (e_wa[3]), .mem_b_1_din_o (e_wd[3])
    );

    fp2_res_unpack #(.RADIX(16), .WIDTH_REAL(7)) dut_o (
        .clk_i (clk), .rst_ni (rst_ni), .start_i (o_start), .target_i (target),
        .busy_o (o_busy), .done_o (o_done),
        .sub_res_rd_en_o (o_sub_rd_en), .sub_res_rd_addr_o (o_sub_rd_addr),
        .sub_res_dout_i (o_sub_dout),
        .add_res_rd_en_o (o_add_rd_en), .add_res_rd_addr_o (o_add_rd_addr),
        .add_res_dout_i (o_add_dout),
        .mem_a_0_wr_en_o (o_wen[0]), .mem_a_0_wr_addr_o (o_wa[0]), .mem_a_0_din_o (o_wd[0]),
        .mem_a_1_wr_en_o (o_wen[1]), .mem_a_1_wr_addr_o (o_wa[1]), .mem_a_1_din_o (o_wd[1]),
        .mem_b_0_wr_en_o (o_wen[2]), .mem_b_0_wr_addr_o (o_wa[2]), .mem_b_0_din_o (o_wd[2]),
        .mem_b_1_wr_en_o (o_wen[3]), .mem_b_1_wr_addr_o (o_wa[3]), .mem_b_1_din_o (o_wd[3])
    );

    // Result memories: one-cycle read latency
    always @(posedge clk) begin
        if (e_sub_rd_en) e_sub_dout <= res_sub[e_sub_rd_addr];
        if (e_add_rd_en) e_add_dout <= res_add[e_add_rd_addr];
        if (o_sub_rd_en) o_sub_dout <= res_sub[o_sub_rd_addr][31:0];
        if (o_add_rd_en) o_add_dout <= res_add[o_add_rd_addr][31:0];
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Digit d lives in word d/2: even digits in the high half, odd digits in the low half.
    function automatic logic [31:0] ref_digit(input bit odd, input logic [63:0] w, input int d);
        if (odd) return (d % 2 == 0) ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
        return (d % 2 == 0) ? w[63:32] : w[31:0];
    endfunction

    task automatic xfer(input bit odd, input bit tgt, input bit pat, input int poke, input bit pre,
                        input bit chain, input int exp_done, input int exp_wr, input int exp_rd);
        logic [31:0] got[4][16];
        int          wc[4];
        int          rd_cnt = 0;
        int          done_cyc = -1;
        int          c;
        int          s0 = tgt ? 2 : 0;
        bit          bad_rd = 0, bad_busy = 0, bad_order = 0;
        logic        ven[4];
        logic [3:0]  va[4];
        logic [31:0] vd[4];
        logic        v_busy, v_done, v_sre, v_are;
        logic [2:0]  v_sra, v_ara;
        logic [31:0] hs, ls, ha, la;
        logic [31:0] expd;

        for (int i = 0; i < 8; i++) begin
            if (pat) begin
                hs = 32'h1000 + 32'(2 * i);
                ls = 32'h1000 + 32'(2 * i + 1);
                ha = 32'h2000 + 32'(2 * i);
                la = 32'h2000 + 32'(2 * i + 1);
                res_sub[i] = odd ? {32'h0, hs[15:0], ls[15:0]} : {hs, ls};
                res_add[i] = odd ? {32'h0, ha[15:0], la[15:0]} : {ha, la};
            end else begin
                res_sub[i] = {$urandom, $urandom};
                res_add[i] = {$urandom, $urandom};
            end
        end
        for (int m = 0; m < 4; m++) begin
            wc[m] = 0;
            for (int d = 0; d < 16; d++) got[m][d] = 32'hDEADBEEF;
        end

        use_odd = odd;
        if (!pre) begin
            @(negedge clk);
            start  = 1'b1;
            target = tgt;
        end
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c <= 40 && done_cyc < 0) begin
            for (int m = 0; m < 4; m++) begin
                ven[m] = odd ? o_wen[m] : e_wen[m];
                va[m]  = odd ? {1'b0, o_wa[m]} : e_wa[m];
                vd[m]  = odd ? {16'h0, o_wd[m]} : e_wd[m];
            end
            v_busy = odd ? o_busy : e_busy;
            v_done = odd ? o_done : e_done;
            v_sre  = odd ? o_sub_rd_en : e_sub_rd_en;
            v_are  = odd ? o_add_rd_en : e_add_rd_en;
            v_sra  = odd ? {1'b0, o_sub_rd_addr} : e_sub_rd_addr;
            v_ara  = odd ? {1'b0, o_add_rd_addr} : e_add_rd_addr;

            for (int m = 0; m < 4; m++) begin
                if (ven[m]) begin
                    if ((m == s0 || m == s0 + 1) && (int'(va[m]) != wc[m] || c != 2 + wc[m]))
                        bad_order = 1;
                    got[m][va[m]] = vd[m];
                    wc[m]++;
                end
            end
            if (v_sre != v_are) bad_rd = 1;
            if (v_sre) begin
                if (int'(v_sra) != rd_cnt || int'(v_ara) != rd_cnt) bad_rd = 1;
                rd_cnt++;
            end
            if ((c < exp_done && !v_busy) || (c >= exp_done && v_busy)) bad_busy = 1;

            if (v_done) begin
                done_cyc = c;
            end else begin
                c++;
                @(negedge clk);
                start = (c == poke);
                if (c == poke) target = ~tgt;
            end
        end

        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("rd_en_count", 64'(rd_cnt), 64'(exp_rd));
        chk("rd_addr_seq_bad", 64'(bad_rd), 64'd0);
        chk("busy_window_bad", 64'(bad_busy), 64'd0);
        chk("wr_order_bad", 64'(bad_order), 64'd0);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("wr_count_mem%0d", m), 64'(wc[m]), (m / 2 == int'(tgt)) ? 64'(exp_wr) : 64'd0);
            for (int d = 0; d < 16; d++) begin
                if (m / 2 == int'(tgt) && d < exp_wr)
                    expd = ref_digit(odd, (m % 2 == 0) ? res_sub[d / 2] : res_add[d / 2], d);
                else
                    expd = 32'hDEADBEEF;
                chk($sformatf("mem%0d[%0d]", m, d), {32'h0, got[m][d]}, {32'h0, expd});
            end
        end

        if (chain) begin
            @(negedge clk);
            start  = 1'b1;
            target = ~tgt;
        end
    endtask

    typedef struct {
        bit odd;
        bit tgt;
        bit pat;
        int poke;
        int exp_done;
        int exp_wr;
        int exp_rd;
    } vec_t;

    vec_t vecs[6];
    bit   saw;

    initial begin
        vecs[0] = '{0, 0, 1, 0, 16, 14, 7};
        vecs[1] = '{1, 1, 1, 0, 9, 7, 4};
        vecs[2] = '{0, 1, 0, 0, 16, 14, 7};
        vecs[3] = '{1, 0, 0, 0, 9, 7, 4};
        vecs[4] = '{0, 0, 0, 5, 16, 14, 7};
        vecs[5] = '{1, 1, 0, 4, 9, 7, 4};

        rst_ni  = 1'b0;
        start   = 1'b0;
        target  = 1'b0;
        use_odd = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_even_ctrl", 64'({e_busy, e_done, e_sub_rd_en, e_add_rd_en, e_sub_rd_addr,
            e_add_rd_addr, e_wen[0], e_wen[1], e_wen[2], e_wen[3]}), 64'd0);
        chk("rst_even_waddr", 64'({e_wa[0], e_wa[1], e_wa[2], e_wa[3]}), 64'd0);
        chk("rst_even_din", 64'(|{e_wd[0], e_wd[1], e_wd[2], e_wd[3]}), 64'd0);
        chk("rst_odd_ctrl", 64'({o_busy, o_done, o_sub_rd_en, o_add_rd_en,
            o_wen[0], o_wen[1], o_wen[2], o_wen[3]}), 64'd0);
        rst_ni = 1'b1;

        for (int k = 0; k < 6; k++)
            xfer(vecs[k].odd, vecs[k].tgt, vecs[k].pat, vecs[k].poke, 1'b0, 1'b0,
                 vecs[k].exp_done, vecs[k].exp_wr, vecs[k].exp_rd);

        // Back-to-back with opposite target, start in the cycle after done
        xfer(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16, 14, 7);
        xfer(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 16, 14, 7);
        xfer(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 9, 7, 4);
        xfer(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 9, 7, 4);

        // Reset in cycle 6 of an even transfer
        use_odd = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        target = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctrl", 64'({e_busy, e_done, e_sub_rd_en, e_add_rd_en, e_sub_rd_addr,
            e_add_rd_addr, e_wen[0], e_wen[1], e_wen[2], e_wen[3]}), 64'd0);
        chk("rst_mid_waddr", 64'({e_wa[0], e_wa[1], e_wa[2], e_wa[3]}), 64'd0);
        chk("rst_mid_din", 64'(|{e_wd[0], e_wd[1], e_wd[2], e_wd[3]}), 64'd0);
        rst_ni = 1'b1;
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            if (e_done || e_busy) saw = 1;
        end
        chk("rst_mid_no_done", 64'(saw), 64'd0);
        xfer(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 16, 14, 7);

        for (int k = 0; k < 6; k++) begin
            bit ro;
            bit rt;
            ro = 1'($urandom_range(0, 1));
            rt = 1'($urandom_range(0, 1));
            xfer(ro, rt, 1'b0, 0, 1'b0, 1'b0, ro ? 9 : 16, ro ? 7 : 14, ro ? 4 : 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
